// File: rtl/id_stage_pkg.sv
// Shared decode constants for the RV32I decode stage: opcodes, funct3
// values, ALU operation codes, instruction format and control bundle.
package id_stage_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ALU funct3 values
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Branch funct3 values
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // ALU operation codes
    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_SLL  = 4'd2;
    localparam logic [3:0] ALU_OP_SLT  = 4'd3;
    localparam logic [3:0] ALU_OP_SLTU = 4'd4;
    localparam logic [3:0] ALU_OP_XOR  = 4'd5;
    localparam logic [3:0] ALU_OP_SRL  = 4'd6;
    localparam logic [3:0] ALU_OP_SRA  = 4'd7;
    localparam logic [3:0] ALU_OP_OR   = 4'd8;
    localparam logic [3:0] ALU_OP_AND  = 4'd9;
    localparam logic [3:0] ALU_OP_PASS = 4'd10;

    // Instruction format; FMT_NONE marks an unrecognised opcode
    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } fmt_e;

    // Pipeline control bundle carried across the ID/EX boundary
    typedef struct packed {
        logic [3:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src;
        logic       branch;
        logic       jump;
    } ctrl_t;

    // ALU op from funct3; alt selects SUB/SRA (callers mask it for I-ALU)
    function automatic logic [3:0] alu_op_from_funct(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD_SUB: return alt ? ALU_OP_SUB : ALU_OP_ADD;
            F3_SLL:     return ALU_OP_SLL;
            F3_SLT:     return ALU_OP_SLT;
            F3_SLTU:    return ALU_OP_SLTU;
            F3_XOR:     return ALU_OP_XOR;
            F3_SRL_SRA: return alt ? ALU_OP_SRA : ALU_OP_SRL;
            F3_OR:      return ALU_OP_OR;
            default:    return ALU_OP_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, x0 hardwired to zero, asynchronous active-low clear.
// Optional macro ID_REGFILE_BYPASS_EN: a same-cycle write is forwarded to
// the read ports (write-first); otherwise reads return the pre-write value.
module id_regfile #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_SEL-1:0]   raddr1,
    input  logic [REG_SEL-1:0]   raddr2,
    output logic [WORD_SIZE-1:0] rdata1,
    output logic [WORD_SIZE-1:0] rdata2,
    input  logic                 we,
    input  logic [REG_SEL-1:0]   waddr,
    input  logic [WORD_SIZE-1:0] wdata
);

    // x0 has no storage; only x1..x(NUM_REGS-1) exist
    logic [WORD_SIZE-1:0] regs_q [1:NUM_REGS-1];
    logic [WORD_SIZE-1:0] regs_d [1:NUM_REGS-1];
    logic                 wr_en;

    assign wr_en = we && (waddr != '0);

    // Next-state: hold every register, overwrite the addressed one
    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_en && (waddr == REG_SEL'(i))) begin
                regs_d[i] = wdata;
            end
        end
    end

    // Register storage with asynchronous clear
    // NOTE: this array is reset on purpose -- architectural state must read 0
    // after reset; ordinary RAM arrays are normally left unreset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: x0 reads zero, optional write-first forwarding
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (raddr1 == REG_SEL'(i)) rdata1 = regs_q[i];
            if (raddr2 == REG_SEL'(i)) rdata2 = regs_q[i];
        end
`ifdef ID_REGFILE_BYPASS_EN
        if (wr_en && (waddr == raddr1)) rdata1 = wdata;
        if (wr_en && (waddr == raddr2)) rdata2 = wdata;
`endif
    end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage. Decodes instr combinationally, reads the
// integrated register file and registers every output into the ID/EX
// boundary. Reset (rst) is asynchronous and active-low.
// Optional macro ID_REGFILE_BYPASS_EN enables write-first forwarding of the
// write-back port into data1/data2 (see id_regfile).
module id_stage
    import id_stage_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] instr,
    input  logic                 reg_write,
    input  logic [WORD_SIZE-1:0] rd_data,
    input  logic [REG_SEL-1:0]   rd_select,
    output logic [WORD_SIZE-1:0] immd,
    output logic [WORD_SIZE-1:0] data1,
    output logic [WORD_SIZE-1:0] data2,
    output logic [3:0]           alu_op,
    output logic [REG_SEL-1:0]   rd,
    output logic [REG_SEL-1:0]   rs1,
    output logic [REG_SEL-1:0]   rs2,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 reg_write_out,
    output logic                 alu_src,
    output logic                 branch,
    output logic                 jump
);

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7_5;
    fmt_e                 fmt;
    logic                 is_shift_imm;

    logic [WORD_SIZE-1:0] immd_d,  immd_q;
    logic [WORD_SIZE-1:0] data1_d, data1_q;
    logic [WORD_SIZE-1:0] data2_d, data2_q;
    logic [REG_SEL-1:0]   rd_d,    rd_q;
    logic [REG_SEL-1:0]   rs1_d,   rs1_q;
    logic [REG_SEL-1:0]   rs2_d,   rs2_q;
    ctrl_t                ctrl_d,  ctrl_q;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7_5 = instr[30];

    // Opcode decode: instruction format and control bundle
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned -- otherwise synthesis infers a latch.
    always_comb begin
        fmt           = FMT_NONE;
        ctrl_d        = '0;
        ctrl_d.alu_op = ALU_OP_ADD;
        case (opcode)
            OPC_R: begin
                fmt              = FMT_R;
                ctrl_d.alu_op    = alu_op_from_funct(funct3, funct7_5);
                ctrl_d.reg_write = 1'b1;
            end
            OPC_I_ALU: begin
                // No SUBI exists; funct7[5] only distinguishes SRAI from SRLI
                fmt              = FMT_I;
                ctrl_d.alu_op    = alu_op_from_funct(funct3, funct7_5 && (funct3 == F3_SRL_SRA));
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                fmt               = FMT_I;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.reg_write  = 1'b1;
            end
            OPC_STORE: begin
                fmt              = FMT_S;
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
            end
            OPC_BRANCH: begin
                fmt            = FMT_B;
                ctrl_d.branch  = 1'b1;
                ctrl_d.alu_src = 1'b1;
                case (funct3)
                    F3_BEQ, F3_BNE:   ctrl_d.alu_op = ALU_OP_SUB;
                    F3_BLT, F3_BGE:   ctrl_d.alu_op = ALU_OP_SLT;
                    F3_BLTU, F3_BGEU: ctrl_d.alu_op = ALU_OP_SLTU;
                    default:          ctrl_d.alu_op = ALU_OP_ADD;
                endcase
            end
            OPC_JAL: begin
                fmt              = FMT_J;
                ctrl_d.jump      = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
            end
            OPC_JALR: begin
                fmt              = FMT_I;
                ctrl_d.jump      = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
            end
            OPC_LUI: begin
                fmt              = FMT_U;
                ctrl_d.alu_op    = ALU_OP_PASS;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                fmt              = FMT_U;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
            end
            default: ;
        endcase
        // A write to x0 is architecturally a no-op, so suppress it here
        ctrl_d.reg_write = ctrl_d.reg_write && (rd_d != '0);
    end

    // Register specifiers, forced to 0 where the format has no such field
    always_comb begin
        rd_d  = '0;
        rs1_d = '0;
        rs2_d = '0;
        if (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) rd_d  = instr[11:7];
        if (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) rs1_d = instr[19:15];
        if (fmt inside {FMT_R, FMT_S, FMT_B})        rs2_d = instr[24:20];
    end

    assign is_shift_imm = (opcode == OPC_I_ALU) &&
                          ((funct3 == F3_SLL) || (funct3 == F3_SRL_SRA));

    // Immediate generation by format
    always_comb begin
        immd_d = '0;
        case (fmt)
            FMT_I: begin
                if (is_shift_imm) immd_d = {{(WORD_SIZE-5){1'b0}}, instr[24:20]};
                else              immd_d = {{(WORD_SIZE-12){instr[31]}}, instr[31:20]};
            end
            FMT_S: immd_d = {{(WORD_SIZE-12){instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: immd_d = {{(WORD_SIZE-13){instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
            FMT_U: immd_d = {instr[WORD_SIZE-1:12], 12'b0};
            FMT_J: immd_d = {{(WORD_SIZE-21){instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
            default: immd_d = '0;
        endcase
    end

    id_regfile #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_REGS  (NUM_REGS),
        .REG_SEL   (REG_SEL)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1_d),
        .raddr2 (rs2_d),
        .rdata1 (data1_d),
        .rdata2 (data2_d),
        .we     (reg_write),
        .waddr  (rd_select),
        .wdata  (rd_data)
    );

    // ID/EX pipeline register
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            immd_q  <= '0;
            data1_q <= '0;
            data2_q <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            immd_q  <= immd_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign immd          = immd_q;
    assign data1         = data1_q;
    assign data2         = data2_q;
    assign rd            = rd_q;
    assign rs1           = rs1_q;
    assign rs2           = rs2_q;
    assign alu_op        = ctrl_q.alu_op;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign reg_write_out = ctrl_q.reg_write;
    assign alu_src       = ctrl_q.alu_src;
    assign branch        = ctrl_q.branch;
    assign jump          = ctrl_q.jump;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: preloads x[i]=i, then issues a table of
// instructions whose expected decode is pushed to a scoreboard queue at
// drive time and popped after the capturing clock edge.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        reg_write;
    logic [31:0] rd_data;
    logic [4:0]  rd_select;
    logic [31:0] immd, data1, data2;
    logic [3:0]  alu_op;
    logic [4:0]  rd, rs1, rs2;
    logic        mem_read, mem_write, mem_to_reg, reg_write_out;
    logic        alu_src, branch, jump;

    int n_checks = 0;
    int n_errors = 0;

    // Control bits ordered {mem_read, mem_write, mem_to_reg, reg_write_out, alu_src, branch, jump}
    typedef struct {
        string       name;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] d1, d2, imm;
        logic [3:0]  alu;
        logic [6:0]  ctl;
    } exp_t;

    exp_t sb[$];

    id_stage u_dut (
        .clk           (clk),
        .rst           (rst),
        .instr         (instr),
        .reg_write     (reg_write),
        .rd_data       (rd_data),
        .rd_select     (rd_select),
        .immd          (immd),
        .data1         (data1),
        .data2         (data2),
        .alu_op        (alu_op),
        .rd            (rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write_out (reg_write_out),
        .alu_src       (alu_src),
        .branch        (branch),
        .jump          (jump)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input string name, input logic [4:0] e_rd, input logic [4:0] e_rs1,
                                input logic [4:0] e_rs2, input logic [31:0] e_d1,
                                input logic [31:0] e_d2, input logic [31:0] e_imm,
                                input logic [3:0] e_alu, input logic [6:0] e_ctl);
        exp_t e;
        e.name = name; e.rd = e_rd; e.rs1 = e_rs1; e.rs2 = e_rs2;
        e.d1 = e_d1; e.d2 = e_d2; e.imm = e_imm; e.alu = e_alu; e.ctl = e_ctl;
        return e;
    endfunction

    function automatic logic [6:0] ctl_now();
        return {mem_read, mem_write, mem_to_reg, reg_write_out, alu_src, branch, jump};
    endfunction

    task automatic compare(input exp_t e);
        check({e.name, ".rd"},  32'(rd),  32'(e.rd));
        check({e.name, ".rs1"}, 32'(rs1), 32'(e.rs1));
        check({e.name, ".rs2"}, 32'(rs2), 32'(e.rs2));
        check({e.name, ".d1"},  data1, e.d1);
        check({e.name, ".d2"},  data2, e.d2);
        check({e.name, ".imm"}, immd,  e.imm);
        check({e.name, ".alu"}, 32'(alu_op), 32'(e.alu));
        check({e.name, ".ctl"}, 32'(ctl_now()), 32'(e.ctl));
    endtask

    // Drive one instruction (optionally with a write-back), score after the edge
    task automatic issue(input logic [31:0] ins, input exp_t e,
                         input logic we, input logic [4:0] wsel, input logic [31:0] wdat);
        exp_t got_e;
        @(negedge clk);
        instr     = ins;
        reg_write = we;
        rd_select = wsel;
        rd_data   = wdat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        if (sb.size() == 0) begin
            check({e.name, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            got_e = sb.pop_front();
            compare(got_e);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".rd"},   32'(rd), 32'd0);
        check({tag, ".rs1"},  32'(rs1), 32'd0);
        check({tag, ".rs2"},  32'(rs2), 32'd0);
        check({tag, ".d1"},   data1, 32'd0);
        check({tag, ".d2"},   data2, 32'd0);
        check({tag, ".imm"},  immd, 32'd0);
        check({tag, ".alu"},  32'(alu_op), 32'd0);
        check({tag, ".ctl"},  32'(ctl_now()), 32'd0);
    endtask

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3;
    localparam logic [3:0] A_SRA = 4'd7, A_PASS = 4'd10;

    initial begin
        logic [31:0] x5_same_edge;
        rst       = 1'b0;
        instr     = 32'h0;
        reg_write = 1'b0;
        rd_data   = 32'h0;
        rd_select = 5'd0;
        #2;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Preload x[i] = i through the write-back port
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            reg_write = 1'b1;
            rd_select = 5'(i);
            rd_data   = 32'(i);
        end
        @(negedge clk);
        reg_write = 1'b0;

        issue(32'h00ee8c33, mk("add",  5'd24, 5'd29, 5'd14, 32'd29, 32'd14, 32'd0, A_ADD, 7'b0001000), 1'b0, 5'd0, 32'd0);
        issue(32'h400bd633, mk("sra",  5'd12, 5'd23, 5'd0,  32'd23, 32'd0,  32'd0, A_SRA, 7'b0001000), 1'b0, 5'd0, 32'd0);
        issue(32'h00eb9013, mk("slli", 5'd0,  5'd23, 5'd0,  32'd23, 32'd0,  32'd14, A_SLL, 7'b0000100), 1'b0, 5'd0, 32'd0);
        issue(32'hed071e23, mk("sh",   5'd0,  5'd14, 5'd16, 32'd14, 32'd16, 32'hFFFFFEDC, A_ADD, 7'b0100100), 1'b0, 5'd0, 32'd0);
        issue(32'h12fc5863, mk("bge",  5'd0,  5'd24, 5'd15, 32'd24, 32'd15, 32'd304, A_SLT, 7'b0000110), 1'b0, 5'd0, 32'd0);
        issue(32'h701010ef, mk("jal",  5'd1,  5'd0,  5'd0,  32'd0,  32'd0,  32'd7936, A_ADD, 7'b0001101), 1'b0, 5'd0, 32'd0);
        issue(32'h04321ab7, mk("lui",  5'd21, 5'd0,  5'd0,  32'd0,  32'd0,  32'h04321000, A_PASS, 7'b0001100), 1'b0, 5'd0, 32'd0);
        issue(32'hffc52283, mk("lw",   5'd5,  5'd10, 5'd0,  32'd10, 32'd0,  32'hFFFFFFFC, A_ADD, 7'b1011100), 1'b0, 5'd0, 32'd0);
        // BNE x3,x3,-2 -> B-type negative offset, SUB
        issue(32'hfe319fe3, mk("bne",  5'd0,  5'd3,  5'd3,  32'd3,  32'd3,  32'hFFFFFFFE, A_SUB, 7'b0000110), 1'b0, 5'd0, 32'd0);
        issue(32'hffffffff, mk("bad_opc", 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, A_ADD, 7'b0000000), 1'b0, 5'd0, 32'd0);

        // Write x0=5, then ADD x1,x0,x0 must still read 0
        issue(32'h00000000, mk("wr_x0", 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, A_ADD, 7'b0000000), 1'b1, 5'd0, 32'd5);
        issue(32'h000000b3, mk("rd_x0", 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, A_ADD, 7'b0001000), 1'b0, 5'd0, 32'd0);

        // ADD x3,x5,x6 with a same-edge write to x5
`ifdef ID_REGFILE_BYPASS_EN
        x5_same_edge = 32'hDEADBEEF;
`else
        x5_same_edge = 32'd5;
`endif
        issue(32'h006281b3, mk("same_edge", 5'd3, 5'd5, 5'd6, x5_same_edge, 32'd6, 32'd0, A_ADD, 7'b0001000), 1'b1, 5'd5, 32'hDEADBEEF);
        issue(32'h006281b3, mk("after_wr",  5'd3, 5'd5, 5'd6, 32'hDEADBEEF, 32'd6, 32'd0, A_ADD, 7'b0001000), 1'b0, 5'd0, 32'd0);

        // Asynchronous reset mid-run: outputs clear before any clock edge
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        issue(32'h00ee8c33, mk("post_reset", 5'd24, 5'd29, 5'd14, 32'd0, 32'd0, 32'd0, A_ADD, 7'b0001000), 1'b0, 5'd0, 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
RV32I instruction-decode stage with an integrated 32x32 register file. It splits the fetched instruction into register specifiers, reads both source operands, generates the sign-extended immediate, and produces the ALU operation and pipeline control signals. All decode outputs are registered into the ID/EX boundary. Write-back from the WB stage enters through the rd_data/rd_select/reg_write port.

Parameters:
WORD_SIZE, 32, datapath and instruction width
NUM_REGS, 32, architectural register count
REG_SEL, 5, register specifier width (log2 NUM_REGS)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
instr  in  WORD_SIZE  instruction to decode
reg_write  in  1  write-back enable
rd_data  in  WORD_SIZE  write-back data
rd_select  in  REG_SEL  write-back destination register
immd  out  WORD_SIZE  decoded immediate
data1  out  WORD_SIZE  value of rs1
data2  out  WORD_SIZE  value of rs2
alu_op  out  4  ALU operation code
rd  out  REG_SEL  destination specifier
rs1  out  REG_SEL  source 1 specifier
rs2  out  REG_SEL  source 2 specifier
mem_read  out  1  load
mem_write  out  1  store
mem_to_reg  out  1  write-back selects memory data
reg_write_out  out  1  instruction writes rd
alu_src  out  1  ALU operand B is immd (1) or data2 (0)
branch  out  1  conditional branch
jump  out  1  JAL/JALR

Behaviour:
- Reset asserted (rst=0): all outputs 0 and all registers x1..x31 cleared to 0; this takes effect asynchronously.
- Latency: decode of instr is combinational and captured on the rising clk edge. Outputs are valid 1 cycle after instr is applied and hold until the next edge.
- Register file writes: on the rising edge, if reg_write=1 and rd_select!=0, then x[rd_select] <= rd_data. x0 always reads 0, and writes to x0 are ignored.
- Register file reads are combinational on rs1/rs2. A same-edge write without the feature returns the old value.
- Unused fields are forced to 0:
  - rd is 0 for S/B.
  - rs1 is 0 for U/J.
  - rs2 is 0 for I/U/J.
  - data1/data2 follow the forced specifiers, so they read x0.
- Immediates:
  - I: sign-extended [31:20]. Shift-immediates use the zero-extended shamt [24:20] only.
  - S: sign-extended {[31:25],[11:7]}.
  - B: sign-extended {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: sign-extended {[31],[19:12],[20],[30:21],0}.
  - R-type: 0.
- reg_write_out is the format's write flag AND (rd!=0).
- alu_op encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS=10 (pass immd).
- Control by opcode:
  - R (0110011): funct3/funct7[5] give ALU op; reg_write=1.
  - I-ALU (0010011): as R, but SUB is not possible and SRAI is selected by funct7[5]; alu_src=1; reg_write=1.
  - LOAD (0000011): ADD; mem_read, mem_to_reg, alu_src, reg_write.
  - STORE (0100011): ADD; mem_write, alu_src.
  - BRANCH (1100011): branch, alu_src. BEQ/BNE use SUB, BLT/BGE use SLT, BLTU/BGEU use SLTU.
  - JAL (1101111): ADD; jump, alu_src, reg_write.
  - JALR (1100111): ADD; jump, alu_src, reg_write.
  - LUI (0110111): PASS; alu_src, reg_write.
  - AUIPC (0010111): ADD; alu_src, reg_write.
  - Any other opcode: all controls 0, alu_op=ADD, immd=0.
- Simultaneous reset and write: reset wins.

Optional Feature:
- Macro: ID_REGFILE_BYPASS_EN.
- When defined: if reg_write=1, rd_select!=0 and rd_select equals rs1 (or rs2), data1 (or data2) captures rd_data in that cycle (write-first forwarding).
- When undefined: the pre-write register value is captured.

Decomposition:
- Shared package/header holds the opcode constants, funct3 values, ALU_OP_* codes and format enum.
- Natural sub-module: id_regfile (2 async read ports, 1 sync write port, x0 hardwired, async active-low clear, bypass under the macro).

Test Plan:
- Preload x[i]=i via the write port.
- ADD x24,x29,x14 (00ee8c33) -> rd=24 rs1=29 rs2=14 d1=29 d2=14 imm=0; ALU_OP_ADD; reg_write_out=1, all other controls 0.
- SRA x12,x23,x0 (400bd633) -> rd=12 rs1=23 rs2=0 d1=23 d2=0 imm=0; SRA; reg_write_out=1.
- SLLI x0,x23,14 (00eb9013) -> rd=0 rs1=23 d1=23 imm=14; SLL; alu_src=1; reg_write_out=0.
- SH x16,-292(x14) (ed071e23) -> rs1=14 rs2=16 d1=14 d2=16 imm=-292; ADD; mem_write=1, alu_src=1.
- BGE x24,x15,304 (12fc5863) -> d1=24 d2=15 imm=304; SLT; branch=1, alu_src=1.
- JAL x1,7936 (701010ef) -> rd=1 imm=7936; ADD; jump=1, reg_write_out=1, alu_src=1.
- LUI x21,0x04321 (04321ab7) -> rd=21 imm=32'h04321000; PASS; reg_write_out=1, alu_src=1.
- Write x0=5 then read -> 0.
- Assert rst mid-run -> outputs and registers 0 immediately.
